// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan controller: FSM state encoding
// and the wrapped next-enabled-channel search.
package adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EMIT
  } scan_state_e;

  localparam int MAX_CH  = 32;
  localparam int MAX_CHW = 5;

  // Returns the lowest set bit strictly above cur, wrapping past nch-1.
  // Passing cur = nch-1 yields the lowest set bit; an empty mask returns cur.
  function automatic int next_channel(input logic [MAX_CH-1:0] mask,
                                      input int nch, input int cur);
    int res;
    int idx;
    res = cur;
    for (int i = MAX_CH; i >= 1; i--) begin
      idx = (cur + i) % nch;
      if (i <= nch && mask[idx[MAX_CHW-1:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// ADC conversion clock divider: adc_clk toggles every CLK_DIV system cycles,
// fall_tick marks the system cycle whose closing edge takes adc_clk 1->0.
module adc_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic adc_clk_o,
  output logic fall_tick_o
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          adc_clk_q, adc_clk_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    adc_clk_d = wrap ? ~adc_clk_q : adc_clk_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
    end
  end

  assign adc_clk_o   = adc_clk_q;
  assign fall_tick_o = wrap & adc_clk_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: scans enabled channels in ascending
// order, averages 2^AVG_LOG2 conversions each and streams tagged results.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int DW       = 12,
  parameter int NCH      = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64,
  localparam int CHW     = $clog2(NCH)
) (
  input  logic           CLK_24MHz,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [NCH-1:0] ch_mask,
  output logic           adc_clk,
  output logic           adc_pd,
  output logic [CHW-1:0] adc_s,
  output logic           adc_soc,
  input  logic           adc_eoc,
  input  logic [DW-1:0]  adc_dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  output logic           err_timeout,
  input  logic           err_clr
);

  localparam int AW   = DW + AVG_LOG2;
  localparam int NW   = AVG_LOG2 + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;
  localparam int NAVG = 1 << AVG_LOG2;

  scan_state_e       state_q, state_d;
  logic [CHW-1:0]    chan_q, chan_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              soc_q, soc_d;
  logic              eoc_prev_q;
  logic              pd_q;
  logic              out_valid_q, out_valid_d;
  logic [CHW-1:0]    out_ch_q, out_ch_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              err_q, err_d;
  logic              set_err;
  logic              fall_tick;
  logic              eoc_edge;
  logic              mask_empty;
  logic [MAX_CH-1:0] mask_ext;
  logic [CHW-1:0]    first_ch, next_ch;

  adc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i       (CLK_24MHz),
    .rst_ni      (rst_n),
    .adc_clk_o   (adc_clk),
    .fall_tick_o (fall_tick)
  );

  assign mask_ext   = MAX_CH'(ch_mask);
  assign mask_empty = (ch_mask == '0);
  assign first_ch   = CHW'(next_channel(mask_ext, NCH, NCH - 1));
  assign next_ch    = CHW'(next_channel(mask_ext, NCH, int'(chan_q)));
  assign eoc_edge   = adc_eoc & ~eoc_prev_q;

  // Everything scan-related advances only on fall_tick so the ADC sees stable
  // inputs at each adc_clk rising edge; the output handshake runs every cycle.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    soc_d       = soc_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    set_err     = 1'b0;
    if (fall_tick) begin
      if (!enable) begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (!mask_empty) begin
              chan_d  = first_ch;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_START;
            end
          end
          S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
          end
          S_WAIT: begin
            if (eoc_edge) begin
              acc_d   = acc_q + AW'(adc_dout);
              cnt_d   = cnt_q + NW'(1);
              state_d = ((cnt_q + NW'(1)) == NW'(NAVG)) ? S_EMIT : S_START;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              set_err = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              chan_d  = next_ch;
              state_d = mask_empty ? S_IDLE : S_START;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
          S_EMIT: begin
            if (!out_valid_q || out_ready) begin
              out_valid_d = 1'b1;
              out_ch_d    = chan_q;
              out_data_d  = acc_q[AW-1:AVG_LOG2];
              acc_d       = '0;
              cnt_d       = '0;
              chan_d      = next_ch;
              state_d     = mask_empty ? S_IDLE : S_START;
            end
          end
        endcase
      end
      soc_d = (state_d == S_START);
    end
    err_d = (err_q & ~err_clr) | set_err;
  end

  always_ff @(posedge CLK_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      soc_q       <= 1'b0;
      eoc_prev_q  <= 1'b0;
      pd_q        <= 1'b1;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      soc_q       <= soc_d;
      pd_q        <= ~enable;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      if (fall_tick) eoc_prev_q <= adc_eoc;
    end
  end

  assign adc_pd      = pd_q;
  assign adc_s       = chan_q;
  assign adc_soc     = soc_q;
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_data    = out_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: behavioural ADC with random latency and data,
// per-channel averaging reference model and one task per scenario.
module tb_adc_scan_ctrl;

  localparam int CLK_DIV  = 1;
  localparam int DW       = 12;
  localparam int NCH      = 8;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int CHW      = $clog2(NCH);
  localparam int NAVG     = 1 << AVG_LOG2;

  logic           CLK_24MHz = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [NCH-1:0] ch_mask;
  logic           adc_clk;
  logic           adc_pd;
  logic [CHW-1:0] adc_s;
  logic           adc_soc;
  logic           adc_eoc;
  logic [DW-1:0]  adc_dout;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;
  logic           err_timeout;
  logic           err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_ch_q[$], exp_data_q[$], got_ch_q[$], got_data_q[$], force_q[$];
  int sum_a[NCH];
  int cnt_a[NCH];
  bit eoc_never = 1'b0;
  bit busy      = 1'b0;

  always #21 CLK_24MHz = ~CLK_24MHz;

  adc_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .DW(DW), .NCH(NCH), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_24MHz   (CLK_24MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .adc_clk     (adc_clk),
    .adc_pd      (adc_pd),
    .adc_s       (adc_s),
    .adc_soc     (adc_soc),
    .adc_eoc     (adc_eoc),
    .adc_dout    (adc_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  // ADC model: latches the channel when it sees soc at an adc_clk rise, then
  // raises eoc for one ADC period a random number of periods later. Every
  // delivered sample feeds the per-channel average used as the expectation.
  initial begin
    int left, conv_ch, val;
    adc_eoc  = 1'b0;
    adc_dout = '0;
    left     = 0;
    conv_ch  = 0;
    forever begin
      @(posedge adc_clk);
      #1;
      adc_eoc = 1'b0;
      if (busy) begin
        left--;
        if (left == 0) begin
          busy = 1'b0;
          if (force_q.size() > 0) val = force_q.pop_front();
          else val = int'($urandom_range(0, (1 << DW) - 1));
          adc_dout = DW'(val);
          if (!eoc_never) begin
            adc_eoc = 1'b1;
            sum_a[conv_ch] += val;
            cnt_a[conv_ch]++;
            if (cnt_a[conv_ch] == NAVG) begin
              exp_ch_q.push_back(conv_ch);
              exp_data_q.push_back(sum_a[conv_ch] / NAVG);
              sum_a[conv_ch] = 0;
              cnt_a[conv_ch] = 0;
            end
          end
        end
      end else if (adc_soc) begin
        busy    = 1'b1;
        conv_ch = int'(adc_s);
        left    = int'($urandom_range(1, 3));
      end
    end
  end

  // Records every word the consumer accepts.
  always @(negedge CLK_24MHz) begin
    if (rst_n && out_valid && out_ready) begin
      got_ch_q.push_back(int'(out_ch));
      got_data_q.push_back(int'(out_data));
    end
  end

  task automatic clear_model();
    busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      sum_a[i] = 0;
      cnt_a[i] = 0;
    end
    exp_ch_q.delete();
    exp_data_q.delete();
    got_ch_q.delete();
    got_data_q.delete();
    force_q.delete();
  endtask

  task automatic applyStimulus(input bit en, input logic [NCH-1:0] m, input bit rdy);
    @(posedge CLK_24MHz);
    #1;
    enable    = en;
    ch_mask   = m;
    out_ready = rdy;
  endtask

  task automatic wait_got(input int want, input int budget, input string name);
    int n = 0;
    while (got_ch_q.size() < want && n < budget) begin
      @(negedge CLK_24MHz);
      n++;
    end
    n_checks++;
    if (got_ch_q.size() < want) begin
      n_fail++;
      $display("[TB] FAIL %s_words: observed %0d required %0d", name, got_ch_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; ch_mask = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge CLK_24MHz);
    n_checks++; if (adc_clk !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_adc_clk: observed %0d required 0", adc_clk); end
    n_checks++; if (adc_pd !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_adc_pd: observed %0d required 1", adc_pd); end
    n_checks++; if (adc_s !== '0) begin n_fail++; $display("[TB] FAIL reset_adc_s: observed %0d required 0", adc_s); end
    n_checks++; if (adc_soc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_adc_soc: observed %0d required 0", adc_soc); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: observed %0d required 0", out_valid); end
    n_checks++; if (out_ch !== '0) begin n_fail++; $display("[TB] FAIL reset_out_ch: observed %0d required 0", out_ch); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data: observed %0d required 0", out_data); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: observed %0d required 0", err_timeout); end
    @(posedge CLK_24MHz);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge CLK_24MHz);
    n_checks++; if (adc_soc !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_soc: observed %0d required 0", adc_soc); end
    n_checks++; if (adc_clk === 1'bx) begin n_fail++; $display("[TB] FAIL idle_adc_clk_known: observed x required 0/1"); end
  endtask

  task automatic test_averaging();
    int n = 0, run = 0, runs = 0, bad = 0;
    clear_model();
    force_q = '{100, 101, 102, 103};
    applyStimulus(1'b1, 8'b0100_0000, 1'b1);
    while (got_ch_q.size() == 0 && n < 2000) begin
      @(negedge CLK_24MHz);
      n++;
      if (adc_soc) run++;
      else if (run > 0) begin
        runs++;
        if (run != 2 * CLK_DIV) bad++;
        run = 0;
      end
    end
    n_checks++;
    if (got_ch_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL avg_result: observed 0 words required 1");
    end else begin
      n_checks++; if (got_ch_q[0] != 6) begin n_fail++; $display("[TB] FAIL avg_ch: observed %0d required 6", got_ch_q[0]); end
      n_checks++; if (got_data_q[0] != 101) begin n_fail++; $display("[TB] FAIL avg_data: observed %0d required 101", got_data_q[0]); end
    end
    n_checks++; if (runs != NAVG) begin n_fail++; $display("[TB] FAIL avg_soc_count: observed %0d required %0d", runs, NAVG); end
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL avg_soc_width: observed %0d bad pulses required 0", bad); end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
  endtask

  task automatic test_scan_order();
    int order[9] = '{0, 2, 7, 0, 2, 7, 0, 3, 3};
    clear_model();
    applyStimulus(1'b1, 8'b1000_0101, 1'b1);
    wait_got(6, 3000, "scan_first");
    applyStimulus(1'b1, 8'b0000_1000, 1'b1);
    wait_got(9, 3000, "scan_second");
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
    for (int i = 0; i < 9 && i < got_ch_q.size(); i++) begin
      n_checks++;
      if (got_ch_q[i] != order[i]) begin
        n_fail++;
        $display("[TB] FAIL scan_ch[%0d]: observed %0d required %0d", i, got_ch_q[i], order[i]);
      end
      n_checks++;
      if (i >= exp_data_q.size() || got_data_q[i] != exp_data_q[i]) begin
        n_fail++;
        $display("[TB] FAIL scan_data[%0d]: observed %0d required %0d", i, got_data_q[i],
                 (i < exp_data_q.size()) ? exp_data_q[i] : -1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, ch0, d0, changed = 0, late_soc = 0;
    int order[3] = '{1, 4, 1};
    clear_model();
    applyStimulus(1'b1, 8'b0001_0010, 1'b0);
    while (!out_valid && n < 2000) begin
      @(negedge CLK_24MHz);
      n++;
    end
    ch0 = int'(out_ch);
    d0  = int'(out_data);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK_24MHz);
      if (out_valid !== 1'b1 || int'(out_ch) != ch0 || int'(out_data) != d0) changed++;
      if (i >= 250 && adc_soc) late_soc++;
    end
    n_checks++; if (changed != 0) begin n_fail++; $display("[TB] FAIL bp_hold: observed %0d changes required 0", changed); end
    n_checks++; if (late_soc != 0) begin n_fail++; $display("[TB] FAIL bp_stall_soc: observed %0d required 0", late_soc); end
    n_checks++; if (got_ch_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_no_accept: observed %0d required 0", got_ch_q.size()); end
    applyStimulus(1'b1, 8'b0001_0010, 1'b1);
    wait_got(3, 2000, "bp_release");
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
    for (int i = 0; i < 3 && i < got_ch_q.size(); i++) begin
      n_checks++;
      if (got_ch_q[i] != order[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_ch[%0d]: observed %0d required %0d", i, got_ch_q[i], order[i]);
      end
      n_checks++;
      if (i >= exp_data_q.size() || got_data_q[i] != exp_data_q[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_data[%0d]: observed %0d required %0d", i, got_data_q[i],
                 (i < exp_data_q.size()) ? exp_data_q[i] : -1);
      end
    end
    if (got_ch_q.size() > 0) begin
      n_checks++;
      if (got_data_q[0] != d0) begin n_fail++; $display("[TB] FAIL bp_first_word: observed %0d required %0d", got_data_q[0], d0); end
    end
  endtask

  task automatic test_timeout();
    int n = 0, seen_valid = 0;
    clear_model();
    eoc_never = 1'b1;
    applyStimulus(1'b1, 8'b0000_0011, 1'b1);
    while (!adc_soc && n < 200) begin
      @(negedge CLK_24MHz);
      n++;
    end
    n_checks++; if (adc_s !== CHW'(0)) begin n_fail++; $display("[TB] FAIL tmo_first_ch: observed %0d required 0", adc_s); end
    n = 0;
    while (!err_timeout && n < 1000) begin
      @(negedge CLK_24MHz);
      n++;
      if (out_valid) seen_valid++;
    end
    n_checks++; if (n != 2 * CLK_DIV * (TIMEOUT + 1)) begin n_fail++; $display("[TB] FAIL tmo_latency: observed %0d cycles required %0d", n, 2 * CLK_DIV * (TIMEOUT + 1)); end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("[TB] FAIL tmo_no_valid: observed %0d required 0", seen_valid); end
    n_checks++; if (adc_soc !== 1'b1 || adc_s !== CHW'(1)) begin n_fail++; $display("[TB] FAIL tmo_next_ch: observed soc %0d ch %0d required soc 1 ch 1", adc_soc, adc_s); end
    @(posedge CLK_24MHz);
    #1 err_clr = 1'b1;
    @(posedge CLK_24MHz);
    #1 err_clr = 1'b0;
    @(negedge CLK_24MHz);
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_clear: observed %0d required 0", err_timeout); end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
    eoc_never = 1'b0;
    clear_model();
  endtask

  task automatic test_disable();
    int n = 0, d0, soc_seen = 0;
    clear_model();
    applyStimulus(1'b1, 8'b0000_0100, 1'b0);
    while (!out_valid && n < 2000) begin
      @(negedge CLK_24MHz);
      n++;
    end
    d0 = int'(out_data);
    n = 0;
    while (adc_soc && n < 20) begin
      @(negedge CLK_24MHz);
      n++;
    end
    applyStimulus(1'b0, 8'b0000_0100, 1'b0);
    repeat (4) @(negedge CLK_24MHz);
    n_checks++; if (adc_pd !== 1'b1) begin n_fail++; $display("[TB] FAIL dis_pd: observed %0d required 1", adc_pd); end
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK_24MHz);
      if (adc_soc) soc_seen++;
    end
    n_checks++; if (soc_seen != 0) begin n_fail++; $display("[TB] FAIL dis_idle_soc: observed %0d required 0", soc_seen); end
    n_checks++; if (out_valid !== 1'b1 || out_ch !== CHW'(2)) begin n_fail++; $display("[TB] FAIL dis_pending: observed valid %0d ch %0d required valid 1 ch 2", out_valid, out_ch); end
    applyStimulus(1'b0, 8'b0000_0100, 1'b1);
    wait_got(1, 50, "dis_pending");
    if (got_ch_q.size() > 0) begin
      n_checks++;
      if (exp_data_q.size() == 0 || got_data_q[0] != exp_data_q[0] || got_data_q[0] != d0) begin
        n_fail++;
        $display("[TB] FAIL dis_pending_data: observed %0d required %0d", got_data_q[0],
                 (exp_data_q.size() > 0) ? exp_data_q[0] : -1);
      end
    end
    clear_model();
    applyStimulus(1'b1, 8'b0000_0100, 1'b1);
    wait_got(1, 2000, "dis_fresh");
    if (got_ch_q.size() > 0) begin
      n_checks++;
      if (exp_data_q.size() == 0 || got_data_q[0] != exp_data_q[0] || got_ch_q[0] != 2) begin
        n_fail++;
        $display("[TB] FAIL dis_fresh_avg: observed %0d required %0d", got_data_q[0],
                 (exp_data_q.size() > 0) ? exp_data_q[0] : -1);
      end
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_model();
    applyStimulus(1'b1, 8'b0000_0001, 1'b1);
    while (!adc_soc && n < 200) begin
      @(negedge CLK_24MHz);
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (adc_soc !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_soc: observed %0d required 0", adc_soc); end
    n_checks++; if (adc_clk !== 1'b0 || adc_pd !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_clk_pd: observed clk %0d pd %0d required clk 0 pd 1", adc_clk, adc_pd); end
    n_checks++; if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0 || adc_s !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_outputs: observed valid %0d ch %0d data %0d s %0d required 0", out_valid, out_ch, out_data, adc_s); end
    repeat (3) @(negedge CLK_24MHz);
    clear_model();
    @(posedge CLK_24MHz);
    #1 rst_n = 1'b1;
    n = 0;
    while (!adc_soc && n < 200) begin
      @(negedge CLK_24MHz);
      n++;
    end
    n_checks++; if (adc_soc !== 1'b1 || adc_s !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_resume: observed soc %0d ch %0d required soc 1 ch 0", adc_soc, adc_s); end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(negedge CLK_24MHz);
  endtask

  initial begin
    $display("[TB] adc_scan_ctrl bench starting");
    test_reset();
    test_averaging();
    test_scan_order();
    test_back_to_back();
    test_timeout();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
